// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter for the shared single-port memory.
// Data wins over fetch unless fetch has been starved; one read in flight.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_t;

  localparam logic [2:0] LAT = 3'(RD_LATENCY);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_wait;
  logic [2:0] w_wait_nxt;
  logic [3:0] r_starve;
  logic [3:0] w_starve_nxt;
  logic       r_owner_d;
  logic       w_owner_nxt;
  logic       w_gnt_i;
  logic       w_gnt_d;
  logic       w_rvalid;
  logic       w_rd;

  // State, countdown, starvation count and read owner registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_wait    <= 3'd0;
      r_starve  <= 4'd0;
      r_owner_d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wait    <= w_wait_nxt;
      r_starve  <= w_starve_nxt;
      r_owner_d <= w_owner_nxt;
    end
  end

  // Grant decision, read tracking and next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_owner_nxt = r_owner_d;
    w_gnt_i     = 1'b0;
    w_gnt_d     = 1'b0;
    w_rvalid    = 1'b0;
    w_rd        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (d_req && !(i_req && r_starve == LIM)) begin
          w_gnt_d = 1'b1;
        end else if (i_req) begin
          w_gnt_i = 1'b1;
        end
        w_rd = w_gnt_i || (w_gnt_d && !d_we);
        if (w_rd) begin
          w_state_nxt = RD_WAIT;
          w_wait_nxt  = LAT;
          w_owner_nxt = w_gnt_d;
        end
      end
      RD_WAIT: begin
        w_wait_nxt = r_wait - 3'd1;
        if (r_wait == 3'd1) begin
          w_rvalid    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  // Fetch starvation count: denied fetch cycles, saturating
  always_comb begin
    w_starve_nxt = r_starve;
    if (!i_req || w_gnt_i) begin
      w_starve_nxt = 4'd0;
    end else if (r_starve != LIM) begin
      w_starve_nxt = r_starve + 4'd1;
    end
  end

  // Memory-side mux and requester responses, silenced during reset
  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    if (!reset) begin
      i_gnt  = w_gnt_i;
      d_gnt  = w_gnt_d;
      mem_re = w_rd;
      mem_we = w_gnt_d && d_we;
      if (w_gnt_d) begin
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_wmask = d_wmask;
      end else if (w_gnt_i) begin
        mem_addr = i_addr;
      end
      i_rvalid = w_rvalid && !r_owner_d;
      d_rvalid = w_rvalid && r_owner_d;
      if (i_rvalid) i_rdata = mem_rdata;
      if (d_rvalid) d_rdata = mem_rdata;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the CPU's single-port unified memory between two requesters: the instruction-fetch port and the load/store data port.
- Sits between the datapath and the memory instance inside top.
- Provides fixed-priority arbitration (data over fetch) with a starvation guard for fetch.
- Tracks one outstanding read and returns its data to the requester that issued it.

Parameters:
ADDR_W, 32, address width for both requesters and memory
DATA_W, 32, data width
RD_LATENCY, 1, memory read latency in cycles from mem_re to valid mem_rdata (legal 1..4)
STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win (legal 1..15)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
i_req  in  1  fetch request, held high until i_gnt
i_addr  in  ADDR_W  fetch address
i_gnt  out  1  fetch grant pulse
i_rvalid  out  1  fetch read data valid pulse
i_rdata  out  DATA_W  fetch read data
d_req  in  1  data request, held high until d_gnt
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_wmask  in  DATA_W/8  store byte enables
d_gnt  out  1  data grant pulse
d_rvalid  out  1  load data valid pulse
d_rdata  out  DATA_W  load data
mem_re  out  1  memory read strobe
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wmask  out  DATA_W/8  memory byte enables
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (async, any state): state=IDLE, wait counter=0, starve counter=0, owner cleared. While reset is high, all outputs are 0.
- States:
  - IDLE: a grant is possible this cycle.
  - RD_WAIT: one read outstanding; the wait counter counts down from RD_LATENCY.
- Grant decision (IDLE only, combinational, same cycle as request):
  - Only d_req high: grant data.
  - Only i_req high: grant fetch.
  - Both high: grant data, unless starve counter == STARVE_LIMIT, in which case grant fetch.
  - Neither high: no grant.
- Grant cycle:
  - Exactly one of i_gnt/d_gnt pulses high for 1 cycle.
  - mem_addr, mem_wdata and mem_wmask are muxed from the winner. Fetch drives mem_wdata=0 and mem_wmask=0.
  - Fetch or data load: mem_re=1. Next state is RD_WAIT, owner is latched, wait counter=RD_LATENCY.
  - Data store: mem_we=1, no rvalid is ever generated, and the state stays IDLE, so back-to-back stores grant every cycle.
- Outside a grant cycle: mem_re=mem_we=0; mem_addr, mem_wdata and mem_wmask are 0.
- RD_WAIT:
  - No grants are issued.
  - Counter decrements each cycle. On the cycle the counter reaches 1, the owner's rvalid is 1 and its rdata = mem_rdata (combinational pass-through).
  - Next state is IDLE, so a new grant can occur the cycle after rvalid.
  - Read latency from grant to rvalid is exactly RD_LATENCY cycles.
- rdata of the non-owner and of any requester without rvalid is 0.
- Starve counter:
  - Increments on each cycle with i_req=1 and i_gnt=0, including RD_WAIT cycles.
  - Saturates at STARVE_LIMIT.
  - Clears to 0 on i_gnt or when i_req=0.
- Requesters must hold req, addr, wdata and wmask stable until gnt. A req that drops before grant is simply not served.
- A requester may reassert req in the cycle after its rvalid.
- Reset mid-RD_WAIT: the outstanding read is discarded, no rvalid is emitted after reset is released, and the first cycle after release is IDLE.

Test Plan:
- RD_LATENCY=1: i_req=1, i_addr=0x0000_0010 alone -> i_gnt and mem_re in cycle 0 with mem_addr=0x10; mem_rdata=0xDEADBEEF in cycle 1 -> i_rvalid=1, i_rdata=0xDEADBEEF in cycle 1; i_gnt possible again in cycle 2.
- d_req=1, d_we=1, d_addr=0x100, d_wdata=0x12345678, d_wmask=4'b0011 for 3 cycles -> d_gnt and mem_we high in all 3 cycles with matching addr/data/mask; d_rvalid and mem_re never high.
- Contention, STARVE_LIMIT=4, d_req always storing, i_req held -> d_gnt for 4 cycles, i_gnt in cycle 4, starve counter back to 0 in cycle 5.
- RD_LATENCY=3, data load at 0x200 with i_req also high -> d_gnt at cycle 0, d_rvalid at cycle 3 only, no i_gnt in cycles 1-3, i_gnt at cycle 4.
- RD_LATENCY=3, reset pulsed in cycle 1 after a fetch grant -> all outputs 0 during reset; no i_rvalid in any cycle afterwards; a new i_req is granted in the first cycle after reset release.
- Both requests drop before grant (in RD_WAIT) -> no grant issued on return to IDLE; mem_re=mem_we=0.
